// File: rtl/master_qp_sched_pkg.sv
// ---------------------------------------------------------------------------
// master_qp_sched_pkg
// Shared definitions for the masterQp scheduler slice.
//   QP_W           : width of every QP value (masterQp, init_qp, flat_qp)
//   QP_MASTER_MIN  : lowest legal masterQp after clamping
//   QP_MASTER_MAX  : highest legal masterQp after clamping
//   state_t        : scheduler FSM state encoding
// ---------------------------------------------------------------------------
package master_qp_sched_pkg;

  localparam int QP_W          = 7;
  localparam int QP_MASTER_MIN = 0;
  localparam int QP_MASTER_MAX = 72;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/master_qp_sched_qp_clamp.sv
// ---------------------------------------------------------------------------
// qp_clamp
// Combinational clamp of a signed 8-bit QP candidate into [QP_MIN, QP_MAX].
// Ports:
//   qp_in  : signed 8-bit candidate (zero-extended QP or QP+delta sum)
//   qp_out : unsigned QP_W-bit clamped result
// ---------------------------------------------------------------------------
module qp_clamp
  import master_qp_sched_pkg::*;
#(
  parameter int QP_MIN = QP_MASTER_MIN,
  parameter int QP_MAX = QP_MASTER_MAX
) (
  input  logic signed [7:0]      qp_in,
  output logic        [QP_W-1:0] qp_out
);

  // int'() of a signed operand sign-extends, so negative sums compare correctly.
  always_comb begin
    if (int'(qp_in) < QP_MIN) begin
      qp_out = QP_W'(QP_MIN);
    end else if (int'(qp_in) > QP_MAX) begin
      qp_out = QP_W'(QP_MAX);
    end else begin
      qp_out = qp_in[QP_W-1:0];
    end
  end

endmodule

// File: rtl/master_qp_sched.sv
// ---------------------------------------------------------------------------
// master_qp_sched
// Per-slice sequencer producing the masterQp stream. Loads init_qp at slice
// start, then applies one rate-control delta (or flat override) per block,
// clamps the result and offers it over valid/ready until the slice's last
// block has been accepted.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   slice_start                    : pulse, (re)starts a slice, top priority
//   init_qp, blocks_per_slice      : slice parameters sampled on slice_start
//   delta_qp, flat_force, flat_qp  : per-block update, qualified by delta_valid
//   delta_valid / delta_ready      : update handshake (ready only in UPDATE)
//   masterQp / masterQp_valid      : QP output, held until masterQp_ready
//   masterQp_ready                 : downstream accept
//   slice_done                     : pulse when the last QP is accepted
// ---------------------------------------------------------------------------
module master_qp_sched
  import master_qp_sched_pkg::*;
#(
  parameter int QP_MIN = QP_MASTER_MIN,
  parameter int QP_MAX = QP_MASTER_MAX,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slice_start,
  input  logic [QP_W-1:0]   init_qp,
  input  logic [CNT_W-1:0]  blocks_per_slice,
  input  logic [QP_W-1:0]   delta_qp,
  input  logic              flat_force,
  input  logic [QP_W-1:0]   flat_qp,
  input  logic              delta_valid,
  output logic              delta_ready,
  output logic [QP_W-1:0]   masterQp,
  output logic              masterQp_valid,
  input  logic              masterQp_ready,
  output logic              slice_done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   blk_cnt, blk_cnt_d;
  logic [CNT_W-1:0]   last_idx, last_idx_d;
  logic [QP_W-1:0]    qp_d;
  logic               valid_d;
  logic               done_d;

  logic signed [7:0]  load_in;
  logic signed [7:0]  upd_sum;
  logic signed [7:0]  upd_in;
  logic [QP_W-1:0]    load_qp;
  logic [QP_W-1:0]    upd_qp;

  // The sum is deliberately 8-bit signed; the clamp then folds it into range.
  assign load_in = $signed({1'b0, init_qp});
  assign upd_sum = $signed({1'b0, masterQp}) + $signed({delta_qp[QP_W-1], delta_qp});
  assign upd_in  = flat_force ? $signed({1'b0, flat_qp}) : upd_sum;

  qp_clamp #(.QP_MIN(QP_MIN), .QP_MAX(QP_MAX)) u_clamp_load (
    .qp_in  (load_in),
    .qp_out (load_qp)
  );

  qp_clamp #(.QP_MIN(QP_MIN), .QP_MAX(QP_MAX)) u_clamp_upd (
    .qp_in  (upd_in),
    .qp_out (upd_qp)
  );

  assign delta_ready = (state_q == UPDATE);

  // Next-state logic. slice_start overrides every state and any handshake
  // happening in the same cycle; an aborted slice never raises slice_done.
  always_comb begin
    state_d    = state_q;
    blk_cnt_d  = blk_cnt;
    last_idx_d = last_idx;
    qp_d       = masterQp;
    valid_d    = masterQp_valid;
    done_d     = 1'b0;

    if (slice_start) begin
      qp_d       = load_qp;
      last_idx_d = (blocks_per_slice == '0) ? '0 : blocks_per_slice - CNT_W'(1);
      blk_cnt_d  = '0;
      valid_d    = 1'b1;
      state_d    = ISSUE;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
        end
        ISSUE: begin
          if (masterQp_ready) begin
            valid_d = 1'b0;
            if (blk_cnt == last_idx) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              blk_cnt_d = blk_cnt + CNT_W'(1);
              state_d   = UPDATE;
            end
          end
        end
        UPDATE: begin
          if (delta_valid) begin
            qp_d    = upd_qp;
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      masterQp       <= '0;
      masterQp_valid <= 1'b0;
      slice_done     <= 1'b0;
      blk_cnt        <= '0;
      last_idx       <= '0;
    end else begin
      state_q        <= state_d;
      masterQp       <= qp_d;
      masterQp_valid <= valid_d;
      slice_done     <= done_d;
      blk_cnt        <= blk_cnt_d;
      last_idx       <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_master_qp_sched.sv
// ---------------------------------------------------------------------------
// tb_master_qp_sched
// Self-checking bench for master_qp_sched: a transaction-level model of the
// scheduler is compared with the DUT every cycle, and directed scenarios add
// literal expectations on the QP stream.
// ---------------------------------------------------------------------------
module tb_master_qp_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        slice_start;
  logic [6:0]  init_qp;
  logic [15:0] blocks_per_slice;
  logic [6:0]  delta_qp;
  logic        flat_force;
  logic [6:0]  flat_qp;
  logic        delta_valid;
  logic        delta_ready;
  logic [6:0]  masterQp;
  logic        masterQp_valid;
  logic        masterQp_ready;
  logic        slice_done;

  int vectors     = 0;
  int miscompares = 0;

  master_qp_sched dut (
    .clk              (clk),
    .rst              (rst),
    .slice_start      (slice_start),
    .init_qp          (init_qp),
    .blocks_per_slice (blocks_per_slice),
    .delta_qp         (delta_qp),
    .flat_force       (flat_force),
    .flat_qp          (flat_qp),
    .delta_valid      (delta_valid),
    .delta_ready      (delta_ready),
    .masterQp         (masterQp),
    .masterQp_valid   (masterQp_valid),
    .masterQp_ready   (masterQp_ready),
    .slice_done       (slice_done)
  );

  always #5 clk = ~clk;

  // Model state: expected outputs plus the number of QPs still to be accepted.
  int  exp_qp      = 0;
  bit  exp_valid   = 0;
  bit  exp_dready  = 0;
  bit  exp_done    = 0;
  int  remaining   = 0;
  bit  model_live  = 0;

  function automatic int clamp_qp(input int x);
    if (x < 0)  return 0;
    if (x > 72) return 72;
    return x;
  endfunction

  // The sum is defined on 8 signed bits.
  function automatic int wrap8(input int x);
    if (x > 127)  return x - 256;
    if (x < -128) return x + 256;
    return x;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Model update on each rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    bit done_n;
    done_n = 0;
    if (rst) begin
      exp_qp = 0; exp_valid = 0; exp_dready = 0; remaining = 0;
      model_live = 1;
    end else if (slice_start) begin
      exp_qp     = clamp_qp(int'(init_qp));
      remaining  = (blocks_per_slice == 0) ? 1 : int'(blocks_per_slice);
      exp_valid  = 1;
      exp_dready = 0;
    end else if (exp_valid && masterQp_ready) begin
      remaining = remaining - 1;
      exp_valid = 0;
      if (remaining == 0) done_n = 1;
      else                exp_dready = 1;
    end else if (exp_dready && delta_valid) begin
      if (flat_force) exp_qp = clamp_qp(int'(flat_qp));
      else            exp_qp = clamp_qp(wrap8(exp_qp + int'($signed(delta_qp))));
      exp_valid  = 1;
      exp_dready = 0;
    end
    exp_done = done_n;
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check_output("masterQp",       int'(masterQp),       exp_qp);
      check_output("masterQp_valid", int'(masterQp_valid), int'(exp_valid));
      check_output("delta_ready",    int'(delta_ready),    int'(exp_dready));
      check_output("slice_done",     int'(slice_done),     int'(exp_done));
    end
  end

  task automatic start_slice(input int qp, input int nblk);
    init_qp          = 7'(qp);
    blocks_per_slice = 16'(nblk);
    slice_start      = 1'b1;
    @(posedge clk); #1;
    slice_start = 1'b0;
  endtask

  // Offer one update and hold it until the scheduler takes it.
  task automatic apply_stimulus(input int d, input bit flat, input int fqp);
    bit taken;
    taken       = 0;
    delta_qp    = 7'(d);
    flat_force  = flat;
    flat_qp     = 7'(fqp);
    delta_valid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      if (delta_ready) begin
        @(posedge clk); #1;
        taken = 1;
      end
    end
    delta_valid = 1'b0;
    flat_force  = 1'b0;
    if (!taken) check_output("delta_handshake_timeout", 0, 1);
  endtask

  // Wait for a valid QP and pin its value.
  task automatic expect_qp(input string name, input int qp);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (masterQp_valid) seen = 1;
    end
    if (!seen) check_output({name, "_valid_timeout"}, 0, 1);
    else       check_output(name, int'(masterQp), qp);
  endtask

  task automatic expect_done(input string name);
    @(negedge clk);
    check_output({name, "_slice_done"},  int'(slice_done),  1);
    check_output({name, "_delta_ready"}, int'(delta_ready), 0);
    @(negedge clk);
    check_output({name, "_done_single"}, int'(slice_done),  0);
  endtask

  initial begin
    rst = 1'b1; slice_start = 1'b0; init_qp = '0; blocks_per_slice = '0;
    delta_qp = '0; flat_force = 1'b0; flat_qp = '0; delta_valid = 1'b0;
    masterQp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_masterQp", int'(masterQp),       0);
    check_output("reset_valid",    int'(masterQp_valid), 0);
    check_output("reset_dready",   int'(delta_ready),    0);

    // Basic slice: 40, 45, 35.
    start_slice(40, 3);
    expect_qp("basic_qp0", 40);
    apply_stimulus(5, 0, 0);
    expect_qp("basic_qp1", 45);
    apply_stimulus(-10, 0, 0);
    expect_qp("basic_qp2", 35);
    expect_done("basic");

    // Clamping: 70 -> 72 -> 8 -> 0.
    start_slice(70, 4);
    expect_qp("clamp_qp0", 70);
    apply_stimulus(6, 0, 0);
    expect_qp("clamp_hi", 72);
    apply_stimulus(-64, 0, 0);
    expect_qp("clamp_mid", 8);
    apply_stimulus(-20, 0, 0);
    expect_qp("clamp_lo", 0);
    expect_done("clamp");

    // Flatness override, including an out-of-range override.
    start_slice(50, 3);
    expect_qp("flat_qp0", 50);
    apply_stimulus(3, 1, 20);
    expect_qp("flat_20", 20);
    apply_stimulus(3, 1, 100);
    expect_qp("flat_100", 72);
    expect_done("flat");

    // Backpressure: QP held, delta_valid pulses ignored outside UPDATE.
    masterQp_ready = 1'b0;
    start_slice(30, 2);
    for (int i = 0; i < 5; i++) begin
      delta_valid = (i % 2 == 0);
      delta_qp    = 7'd9;
      @(negedge clk);
      check_output("bp_qp",     int'(masterQp),       30);
      check_output("bp_valid",  int'(masterQp_valid), 1);
      check_output("bp_dready", int'(delta_ready),    0);
    end
    delta_valid    = 1'b0;
    masterQp_ready = 1'b1;
    apply_stimulus(2, 0, 0);
    expect_qp("bp_after", 32);
    expect_done("bp");

    // Restart while in UPDATE with blk_cnt=2, with a delta in the same cycle.
    start_slice(60, 5);
    expect_qp("abort_qp0", 60);
    apply_stimulus(1, 0, 0);
    expect_qp("abort_qp1", 61);
    @(negedge clk);
    check_output("abort_in_update", int'(delta_ready), 1);
    delta_valid = 1'b1; delta_qp = 7'd7;
    start_slice(10, 5);
    delta_valid = 1'b0;
    @(negedge clk);
    check_output("restart_qp",    int'(masterQp),       10);
    check_output("restart_valid", int'(masterQp_valid), 1);
    check_output("restart_done",  int'(slice_done),     0);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1, 0, 0);
      expect_qp("restart_seq", 10 + i);
    end
    expect_done("restart");

    // blocks_per_slice = 0 issues exactly one QP.
    start_slice(5, 0);
    expect_qp("zero_blk_qp", 5);
    expect_done("zero_blk");

    // Reset in the middle of a slice.
    start_slice(33, 4);
    expect_qp("rst_mid_qp0", 33);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_mid_qp",    int'(masterQp),       0);
    check_output("rst_mid_valid", int'(masterQp_valid), 0);
    check_output("rst_mid_done",  int'(slice_done),     0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/master_qp_sched.md
Name: master_qp_sched

Overview:
- Per-slice sequencer that produces the masterQp stream consumed by the masterQp-to-component-QP mapping stage.
- Loads an initial QP at slice start, then applies one rate-control delta (or a flatness override) per block.
- Clamps each result to the legal master range and presents it over a valid/ready handshake.
- Counts blocks so it stops issuing after the last block of the slice.

Parameters:
- QP_MIN, 0, lowest legal masterQp after clamping.
- QP_MAX, 72, highest legal masterQp after clamping.
- CNT_W, 16, width of the block counter and of blocks_per_slice.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- slice_start  in  1  single-cycle pulse; starts (or restarts) a slice.
- init_qp  in  7  slice initial masterQp; sampled when slice_start=1.
- blocks_per_slice  in  CNT_W  number of QPs to issue per slice; sampled when slice_start=1.
- delta_qp  in  7  signed rate-control QP delta for the next block.
- flat_force  in  1  when 1 together with delta_valid, flat_qp replaces masterQp+delta_qp.
- flat_qp  in  7  override QP, used only when flat_force=1.
- delta_valid  in  1  delta_qp, flat_force and flat_qp are valid.
- delta_ready  out  1  scheduler accepts an update this cycle.
- masterQp  out  7  current master QP, unsigned.
- masterQp_valid  out  1  masterQp is valid and held stable until accepted.
- masterQp_ready  in  1  downstream accepts masterQp.
- slice_done  out  1  single-cycle pulse when the last QP of the slice is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, masterQp=0, masterQp_valid=0, delta_ready=0, slice_done=0, blk_cnt=0, last_idx=0.
- All outputs are registered; delta_ready is a decode of the state register only.
- FSM has three states: IDLE, ISSUE, UPDATE.
- IDLE:
  - delta_ready=0, masterQp_valid=0.
  - On slice_start: masterQp <= clamp(init_qp); last_idx <= max(blocks_per_slice,1)-1; blk_cnt <= 0; masterQp_valid <= 1; go to ISSUE.
- ISSUE:
  - masterQp_valid=1; masterQp stays stable while masterQp_ready=0.
  - On masterQp_ready, if blk_cnt==last_idx: masterQp_valid <= 0, slice_done <= 1 for one cycle, go to IDLE.
  - On masterQp_ready otherwise: blk_cnt <= blk_cnt+1, masterQp_valid <= 0, go to UPDATE.
- UPDATE:
  - delta_ready=1.
  - On delta_valid: masterQp <= flat_force ? clamp(flat_qp) : clamp(masterQp + delta_qp); masterQp_valid <= 1; go to ISSUE.
  - Latency from delta handshake to new masterQp_valid is 1 cycle.
- Arithmetic:
  - Sum is formed at 8 bits signed: {1'b0, masterQp} + sign-extended delta_qp.
  - clamp(x): x<QP_MIN gives QP_MIN; x>QP_MAX gives QP_MAX; otherwise x.
  - clamp is applied identically to init_qp and flat_qp, each zero-extended first.
- Throughput: at most one QP every 2 cycles (ISSUE accept, then UPDATE accept).
- Boundary conditions:
  - slice_start in any state has top priority. It aborts the current slice, discards any pending handshake, performs the IDLE load, and asserts no slice_done for the aborted slice.
  - slice_start in the same cycle as a masterQp or delta handshake: the handshake is ignored and the load wins.
  - blocks_per_slice=0 is treated as 1.
  - delta_valid while not in UPDATE is ignored. Upstream must hold its data until delta_ready.
  - masterQp_ready while masterQp_valid=0 is ignored.
  - rst mid-slice returns to the reset values on the next edge. No slice_done is asserted.
  - blk_cnt never wraps; it stops at last_idx.

Decomposition:
- Shared decoder package holds:
  - constants QP_MASTER_MIN=0 and QP_MASTER_MAX=72;
  - the 7-bit QP width constant;
  - the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, UPDATE=2'd2).
- One natural sub-module, qp_clamp: combinational 8-bit signed input, 7-bit output, parameterised by QP_MIN/QP_MAX. It is instanced for the load path and the update path.

Test Plan:
- Reset then slice_start, init_qp=40, blocks_per_slice=3, masterQp_ready=1 -> masterQp=40 valid the cycle after start.
- Continue with deltas +5 then -10 -> QPs 40, 45, 35; slice_done pulses once on the 3rd accept; return to IDLE with delta_ready=0.
- Clamping: init_qp=70, delta=+6 -> 72; then delta=-64 -> 8; then delta=-20 -> 0.
- Flatness override: masterQp=50, delta_valid with flat_force=1, flat_qp=20, delta_qp=+3 -> 20. Separately flat_qp=100 -> 72.
- Backpressure: masterQp_ready=0 for 5 cycles during ISSUE -> masterQp and valid held stable; delta_ready stays 0 and delta_valid pulses are ignored.
- slice_start while in UPDATE with blk_cnt=2, init_qp=10 -> next cycle masterQp=10, valid=1, blk_cnt=0, no slice_done. Also check blocks_per_slice=0 -> exactly one QP, then slice_done.
